multi_input_nand_array_sync: RTL and testbench

//  Clocked, parametrised successor to the dual 4-input NAND gate model: CHANNELS independent INPUTS-wide gates.

---
 rtl/multi_input_nand_array_sync_pkg.sv | 23 ++
 rtl/multi_input_nand_array_sync_if.sv | 30 +++
 rtl/multi_input_nand_array_sync_gate_delay_line.sv | 25 ++
 rtl/multi_input_nand_array_sync.sv | 115 +++++++++++
 tb/tb_multi_input_nand_array_sync.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/multi_input_nand_array_sync_pkg.sv
// Shared definitions for the 74LSXX gate-array primitive: function-select
// encodings, the reset level of the gate outputs and the gate evaluator.
package multi_input_nand_array_sync_pkg;

  typedef enum logic [1:0] {
    MODE_NAND = 2'b00,
    MODE_AND  = 2'b01,
    MODE_NOR  = 2'b10,
    MODE_OR   = 2'b11
  } gate_mode_e;

  // NAND of idle-low inputs is high, so outputs come out of reset at 1.
  localparam logic RESET_Y_LEVEL = 1'b1;

  // mode[1] picks the reduction (OR-family vs AND-family), mode[0] clear
  // means the inverted flavour; inversion is applied last.
  function automatic logic gate_eval(gate_mode_e mode, logic all_high, logic any_high);
    logic base;
    base = mode[1] ? any_high : all_high;
    return mode[0] ? base : ~base;
  endfunction

endpackage

// File: rtl/multi_input_nand_array_sync_if.sv
// Bus bundle for the gate array: sample inputs, mode programming, counter
// clear, and the registered gate outputs with their toggle counters.
interface multi_input_nand_array_sync_if #(
  parameter int CHANNELS = 2,
  parameter int INPUTS   = 4,
  parameter int CNT_W    = 8
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS*INPUTS-1:0] in_data;
  logic                       in_valid;
  logic                       mode_wr;
  logic [CH_W-1:0]            mode_ch;
  logic [1:0]                 mode_val;
  logic                       cnt_clr;
  logic [CHANNELS-1:0]        y;
  logic                       y_valid;
  logic [CHANNELS*CNT_W-1:0]  toggle_cnt;

  modport master (
    output in_data, in_valid, mode_wr, mode_ch, mode_val, cnt_clr,
    input  y, y_valid, toggle_cnt
  );

  modport slave (
    input  in_data, in_valid, mode_wr, mode_ch, mode_val, cnt_clr,
    output y, y_valid, toggle_cnt
  );

endinterface

// File: rtl/multi_input_nand_array_sync_gate_delay_line.sv
// One channel's gate-delay model: a DEPTH-stage data shift register that
// advances every cycle. Validity travels in a parallel pipe owned by the top.
module multi_input_nand_array_sync_gate_delay_line #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] taps;

  // Shift the gate result one stage per clock.
  // NOTE: data stages carry no reset; the top's valid pipe is reset and only
  // a valid-tagged stage is ever allowed to reach the output register.
  always_ff @(posedge clk) begin
    taps[0] <= d;
    for (int i = 1; i < DEPTH; i++) begin
      taps[i] <= taps[i-1];
    end
  end

  assign q = taps[DEPTH-1];

endmodule

// File: rtl/multi_input_nand_array_sync.sv
// Clocked CHANNELS x INPUTS gate array with per-channel NAND/AND/NOR/OR
// select, a DELAY_CYCLES valid-tagged pipe, registered outputs and
// saturating per-channel output-toggle counters.
module multi_input_nand_array_sync
  import multi_input_nand_array_sync_pkg::*;
#(
  parameter int CHANNELS     = 2,
  parameter int INPUTS       = 4,
  parameter int DELAY_CYCLES = 2,
  parameter int CNT_W        = 8
) (
  input logic                          clk,
  input logic                          reset_n,
  multi_input_nand_array_sync_if.slave bus
);

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  gate_mode_e              mode_q [CHANNELS];
  logic [CHANNELS-1:0]     func_res;
  logic [CHANNELS-1:0]     dl_out;
  logic [DELAY_CYCLES-1:0] vld_pipe;
  logic                    vld_last;
  logic [CHANNELS-1:0]     y_q;
  logic                    y_valid_q;
  logic [CNT_W-1:0]        cnt_q [CHANNELS];
  logic [CHANNELS*CNT_W-1:0] cnt_flat;

  // Per-channel mode registers; out-of-range channel numbers match nothing.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  // NOTE: this array is reset element by element because the reset mode
  // is observable behaviour, unlike the unreset data delay stages.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < CHANNELS; c++) mode_q[c] <= MODE_NAND;
    end else if (bus.mode_wr) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (bus.mode_ch == CH_W'(c)) mode_q[c] <= gate_mode_e'(bus.mode_val);
      end
    end
  end

  // Gate function of each input slice under that channel's current mode.
  // NOTE: the vector gets a default before the loop so no path through this
  // block can leave a bit unassigned and infer a latch.
  always_comb begin
    func_res = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      func_res[c] = gate_eval(mode_q[c],
                              &bus.in_data[c*INPUTS +: INPUTS],
                              |bus.in_data[c*INPUTS +: INPUTS]);
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    multi_input_nand_array_sync_gate_delay_line #(
      .DEPTH (DELAY_CYCLES)
    ) u_gate_delay_line (
      .clk (clk),
      .d   (func_res[c]),
      .q   (dl_out[c])
    );
  end

  // Shared valid tag pipe; bubbles travel as zeros and reset flushes it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= bus.in_valid;
      for (int i = 1; i < DELAY_CYCLES; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  assign vld_last = vld_pipe[DELAY_CYCLES-1];

  // Output register: load on a valid tag, otherwise hold and drop y_valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      y_q       <= {CHANNELS{RESET_Y_LEVEL}};
      y_valid_q <= 1'b0;
    end else begin
      y_valid_q <= vld_last;
      if (vld_last) y_q <= dl_out;
    end
  end

  // Saturating toggle counters; a clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < CHANNELS; c++) cnt_q[c] <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (bus.cnt_clr) begin
          cnt_q[c] <= '0;
        end else if (vld_last && (dl_out[c] != y_q[c]) && (cnt_q[c] != CNT_MAX)) begin
          cnt_q[c] <= cnt_q[c] + 1'b1;
        end
      end
    end
  end

  // Flatten the counter array onto the bus.
  always_comb begin
    cnt_flat = '0;
    for (int c = 0; c < CHANNELS; c++) cnt_flat[c*CNT_W +: CNT_W] = cnt_q[c];
  end

  assign bus.y          = y_q;
  assign bus.y_valid    = y_valid_q;
  assign bus.toggle_cnt = cnt_flat;

endmodule

// File: tb/tb_multi_input_nand_array_sync.sv
// Scoreboard bench: the stimulus side predicts each sample's gate result and
// arrival cycle into a queue; an independent monitor pops, compares, and
// tracks the expected held output value and toggle counts.
module tb_multi_input_nand_array_sync;
  import multi_input_nand_array_sync_pkg::*;

  localparam int CH  = 3;
  localparam int IN  = 4;
  localparam int DLY = 2;
  localparam int CW  = 2;
  localparam int CHW = 2;
  localparam int CNT_SAT = (1 << CW) - 1;

  typedef struct {
    logic [CH-1:0] y;
    int            due;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  multi_input_nand_array_sync_if #(.CHANNELS(CH), .INPUTS(IN), .CNT_W(CW)) bus ();

  multi_input_nand_array_sync #(
    .CHANNELS     (CH),
    .INPUTS       (IN),
    .DELAY_CYCLES (DLY),
    .CNT_W        (CW)
  ) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  int   model_mode [CH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Spec-level gate: count the high inputs and apply the named function.
  function automatic logic ref_gate(input int mode, input logic [IN-1:0] bits);
    int ones;
    ones = 0;
    for (int i = 0; i < IN; i++) ones += int'(bits[i]);
    case (mode)
      0:       return !(ones == IN);   // NAND
      1:       return  (ones == IN);   // AND
      2:       return !(ones != 0);    // NOR
      default: return  (ones != 0);    // OR
    endcase
  endfunction

  // One clock of stimulus; predictions use the modes in force before any
  // coincident write.
  task automatic drive(input logic valid, input logic [CH*IN-1:0] data,
                       input logic wr, input logic [CHW-1:0] ch,
                       input logic [1:0] val, input logic clr);
    exp_t e;
    @(posedge clk);
    #1;
    bus.in_valid = valid;
    bus.in_data  = data;
    bus.mode_wr  = wr;
    bus.mode_ch  = ch;
    bus.mode_val = val;
    bus.cnt_clr  = clr;
    if (valid) begin
      for (int c = 0; c < CH; c++) e.y[c] = ref_gate(model_mode[c], data[c*IN +: IN]);
      e.due = cyc + 1 + DLY;
      exp_q.push_back(e);
    end
    if (wr && (int'(ch) < CH)) model_mode[ch] = int'(val);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0, 2'b00, 1'b0);
  endtask

  task automatic apply_reset(input int hold);
    @(posedge clk);
    #1;
    reset_n      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.mode_wr  = 1'b0;
    bus.mode_ch  = '0;
    bus.mode_val = 2'b00;
    bus.cnt_clr  = 1'b0;
    exp_q.delete();
    for (int c = 0; c < CH; c++) model_mode[c] = 0;
    repeat (hold) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Monitor: compare outputs at the falling edge after each rising edge.
  initial begin
    logic [CH-1:0] model_y;
    int            model_cnt [CH];
    logic          clr_e;
    logic          exp_valid;
    exp_t          e;
    model_y = '1;
    for (int c = 0; c < CH; c++) model_cnt[c] = 0;
    forever begin
      @(posedge clk);
      cyc++;
      clr_e = bus.cnt_clr;
      @(negedge clk);
      if (!reset_n) begin
        model_y = '1;
        for (int c = 0; c < CH; c++) model_cnt[c] = 0;
        check("rst_y", 32'(bus.y), 32'(model_y));
        check("rst_y_valid", 32'(bus.y_valid), 32'd0);
        check("rst_cnt", 32'(bus.toggle_cnt), 32'd0);
      end else begin
        exp_valid = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        check("y_valid", 32'(bus.y_valid), 32'(exp_valid));
        if (exp_valid) begin
          e = exp_q.pop_front();
          for (int c = 0; c < CH; c++) begin
            if (e.y[c] != model_y[c] && model_cnt[c] < CNT_SAT) model_cnt[c]++;
          end
          model_y = e.y;
        end
        if (clr_e) begin
          for (int c = 0; c < CH; c++) model_cnt[c] = 0;
        end
        check("y", 32'(bus.y), 32'(model_y));
        for (int c = 0; c < CH; c++) begin
          check($sformatf("toggle_cnt[%0d]", c),
                32'(bus.toggle_cnt[c*CW +: CW]), 32'(model_cnt[c]));
        end
      end
    end
  end

  // Stimulus: directed scenarios, then randomized traffic.
  initial begin
    logic [CH*IN-1:0] d;
    for (int c = 0; c < CH; c++) model_mode[c] = 0;
    reset_n      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.mode_wr  = 1'b0;
    bus.mode_ch  = '0;
    bus.mode_val = 2'b00;
    bus.cnt_clr  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Idle after reset: outputs all high, no valid, counters zero.
    idle(5);

    // Channel 0 latency: 1111 then 0111 under NAND.
    drive(1'b1, 12'h00F, 1'b0, '0, 2'b00, 1'b0);
    drive(1'b1, 12'h007, 1'b0, '0, 2'b00, 1'b0);
    idle(3);

    // Mode write coincident with a sample, then an out-of-range write.
    drive(1'b1, 12'h000, 1'b1, 2'd1, MODE_OR, 1'b0);
    drive(1'b1, 12'h000, 1'b0, '0, 2'b00, 1'b0);
    drive(1'b0, 12'h000, 1'b1, 2'd3, MODE_AND, 1'b0);
    drive(1'b1, 12'h000, 1'b0, '0, 2'b00, 1'b0);
    idle(3);

    // Bubbles: valid, gap, valid.
    drive(1'b1, 12'h0F0, 1'b0, '0, 2'b00, 1'b0);
    drive(1'b0, 12'hFFF, 1'b0, '0, 2'b00, 1'b0);
    drive(1'b1, 12'h00F, 1'b0, '0, 2'b00, 1'b0);
    idle(3);

    // Saturation: toggle channel 0 repeatedly, then clear on a toggle edge.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, (i % 2 == 0) ? 12'h000 : 12'h00F, 1'b0, '0, 2'b00, 1'b0);
    end
    drive(1'b1, 12'h000, 1'b0, '0, 2'b00, 1'b0);
    drive(1'b0, 12'h000, 1'b0, '0, 2'b00, 1'b0);
    drive(1'b0, 12'h000, 1'b0, '0, 2'b00, 1'b1);
    idle(3);

    // Reset with a sample in flight; afterwards channel 1 must be NAND again.
    drive(1'b1, 12'h00F, 1'b1, 2'd2, MODE_NOR, 1'b0);
    apply_reset(2);
    idle(3);
    drive(1'b1, 12'h000, 1'b0, '0, 2'b00, 1'b0);
    idle(3);

    // Randomized traffic with biased per-channel input patterns.
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < CH; c++) begin
        case ($urandom_range(0, 2))
          0:       d[c*IN +: IN] = '1;
          1:       d[c*IN +: IN] = '0;
          default: d[c*IN +: IN] = IN'($urandom);
        endcase
      end
      drive($urandom_range(0, 3) != 0, d,
            $urandom_range(0, 7) == 0, CHW'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), $urandom_range(0, 15) == 0);
    end

    idle(6);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Global bound so a stuck run still ends with a report.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
